// File: rtl/pwm_gen_axil_slave.sv
// ----------------------------------------------------------------------------
// pwm_gen_axil_slave
//
// AXI4-Lite slave register file and PWM generator core for axi_pwm_gen.
//
// Registers (byte address, decode on addr[3:2]):
//   0x0 CTRL    bit0 en, bit1 pol (other bits read 0)
//   0x4 PERIOD  period in cycles
//   0x8 DUTY    active cycles per period
//   0xC STATUS  read-only: bit0 running, bits[31:16] wrap_cnt (writes dropped)
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*   write address / data channels (latched independently)
//   S_AXI_B*               write response, BRESP always OKAY
//   S_AXI_AR* / S_AXI_R*   read address / data channels, RRESP always OKAY
//   pwm_out                registered PWM output
//
// Build option:
//   PWM_GEN_SHADOW_EN  when defined, the PWM core uses shadow copies of
//                      PERIOD/DUTY that reload only at a period boundary (or
//                      while idle), so mid-period writes are glitch-free.
//                      When undefined, PERIOD/DUTY act on the next cycle.
// ----------------------------------------------------------------------------
module pwm_gen_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    // Write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // Write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // Write response channel
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // Read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // Read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // PWM
    output logic                            pwm_out
);

    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegPeriod = 2'd1,
        RegDuty   = 2'd2,
        RegStatus = 2'd3
    } reg_sel_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Goes high on the first clock after reset release so every READY is low
    // while ARESETN is asserted.
    logic        init_q;

    logic        aw_q,     aw_d;
    reg_sel_e    awsel_q,  awsel_d;
    logic        w_q,      w_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic        bvalid_q, bvalid_d;

    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q,  rdata_d;

    logic [1:0]  ctrl_q,   ctrl_d;
    logic [31:0] period_q, period_d;
    logic [31:0] duty_q,   duty_d;

    logic [31:0] cnt_q,    cnt_d;
    logic [15:0] wrap_q,   wrap_d;
    logic        pwm_q,    pwm_d;

    logic [31:0] period_act;
    logic [31:0] duty_act;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    logic aw_ready, w_ready, ar_ready;
    logic aw_hs, w_hs, ar_hs;
    logic wr_fire;

    assign aw_ready = init_q & ~aw_q & ~bvalid_q;
    assign w_ready  = init_q & ~w_q  & ~bvalid_q;
    assign ar_ready = init_q & ~rvalid_q;

    assign aw_hs = S_AXI_AWVALID & aw_ready;
    assign w_hs  = S_AXI_WVALID  & w_ready;
    assign ar_hs = S_AXI_ARVALID & ar_ready;

    // Commit as soon as both halves are present, whether latched earlier or
    // arriving this cycle.
    assign wr_fire = (aw_q | aw_hs) & (w_q | w_hs);

    // Selected write address/data: latched copy if present, else live bus.
    reg_sel_e    wr_sel;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_old;
    logic [31:0] wr_merged;

    assign wr_sel  = aw_q ? awsel_q : reg_sel_e'(S_AXI_AWADDR[3:2]);
    assign wr_data = w_q ? wdata_q : S_AXI_WDATA[31:0];
    assign wr_strb = w_q ? wstrb_q : S_AXI_WSTRB[3:0];

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        wr_old = 32'd0;
        case (wr_sel)
            RegCtrl:   wr_old = {30'd0, ctrl_q};
            RegPeriod: wr_old = period_q;
            RegDuty:   wr_old = duty_q;
            default:   wr_old = 32'd0;
        endcase
    end

    assign wr_merged = apply_strb(wr_old, wr_data, wr_strb);

    // ------------------------------------------------------------------------
    // Write path next state
    // ------------------------------------------------------------------------
    always_comb begin
        aw_d     = aw_q;
        awsel_d  = awsel_q;
        w_d      = w_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;

        if (aw_hs) begin
            awsel_d = reg_sel_e'(S_AXI_AWADDR[3:2]);
        end
        if (w_hs) begin
            wdata_d = S_AXI_WDATA[31:0];
            wstrb_d = S_AXI_WSTRB[3:0];
        end

        if (wr_fire) begin
            aw_d     = 1'b0;
            w_d      = 1'b0;
            bvalid_d = 1'b1;
            case (wr_sel)
                RegCtrl:   ctrl_d   = wr_merged[1:0];
                RegPeriod: period_d = wr_merged;
                RegDuty:   duty_d   = wr_merged;
                default:   ;  // STATUS is read-only; write is acknowledged only
            endcase
        end else begin
            aw_d = aw_q | aw_hs;
            w_d  = w_q  | w_hs;
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path next state
    // ------------------------------------------------------------------------
    logic        running;
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    assign running     = ctrl_q[0] & (period_act != 32'd0);
    assign status_word = {wrap_q, 15'd0, running};

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel_e'(S_AXI_ARADDR[3:2]))
            RegCtrl:   rd_mux = {30'd0, ctrl_q};
            RegPeriod: rd_mux = period_q;
            RegDuty:   rd_mux = duty_q;
            RegStatus: rd_mux = status_word;
            default:   rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // PWM core
    // ------------------------------------------------------------------------
    logic en, pol, active, at_end;

    assign en     = ctrl_q[0];
    assign pol    = ctrl_q[1];
    assign active = en & (period_act != 32'd0);
    // >= rather than == so a shortened period never lets cnt run away.
    assign at_end = cnt_q >= (period_act - 32'd1);

`ifdef PWM_GEN_SHADOW_EN
    logic [31:0] period_act_q, period_act_d;
    logic [31:0] duty_act_q,   duty_act_d;
    logic        shadow_load;

    assign period_act  = period_act_q;
    assign duty_act    = duty_act_q;
    assign shadow_load = ~active | at_end;

    always_comb begin
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (shadow_load) begin
            period_act_d = period_q;
            duty_act_d   = duty_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            period_act_q <= 32'd0;
            duty_act_q   <= 32'd0;
        end else begin
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
        end
    end
`else
    assign period_act = period_q;
    assign duty_act   = duty_q;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        if (!active) begin
            cnt_d = 32'd0;
        end else if (at_end) begin
            cnt_d  = 32'd0;
            wrap_d = wrap_q + 16'd1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        if (!en) begin
            wrap_d = 16'd0;
        end
        pwm_d = (active & (cnt_q < duty_act)) ^ pol;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q   <= 1'b0;
            aw_q     <= 1'b0;
            awsel_q  <= RegCtrl;
            w_q      <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            ctrl_q   <= 2'd0;
            period_q <= 32'd0;
            duty_q   <= 32'd0;
            cnt_q    <= 32'd0;
            wrap_q   <= 16'd0;
            pwm_q    <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            aw_q     <= aw_d;
            awsel_q  <= awsel_d;
            w_q      <= w_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            pwm_q    <= pwm_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign pwm_out       = pwm_q;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------------
    bvalid_hold_a: assert property (@(posedge ACLK) disable iff (!ARESETN)
        (bvalid_q && !S_AXI_BREADY) |=> bvalid_q);

    rvalid_hold_a: assert property (@(posedge ACLK) disable iff (!ARESETN)
        (rvalid_q && !S_AXI_RREADY) |=> (rvalid_q && $stable(rdata_q)));

endmodule

// File: tb/tb_pwm_gen_axil_slave.sv
module tb_pwm_gen_axil_slave;

    logic        ACLK;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        pwm_out;

    int tests_run;
    int tests_failed;

    pwm_gen_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .pwm_out       (pwm_out)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        n = 0;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL write_ready_timeout: addr 0x%0h never accepted", addr);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("bvalid_after_write", {31'd0, S_AXI_BVALID}, 32'd1);
        chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL read_ready_timeout: addr 0x%0h never accepted", addr);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("rvalid_after_ar", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        data = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    // Reference: k cycles after the first active sample, the output is
    // ((k mod P) < D) ^ pol; wrap count seen by a read issued at sample k is
    // floor((k+1)/P).
    function automatic logic ref_pwm(input int k, input int p, input int d, input logic pol);
        if (p == 0) return pol;
        return ((k % p) < d) ^ pol;
    endfunction

    task automatic run_pwm(input int p, input int d, input logic pol, input int ncyc);
        logic [31:0] rd;
        logic [15:0] wexp;
        axi_write(4'h4, p, 4'hF);
        axi_write(4'h8, d, 4'hF);
        axi_write(4'h0, {30'd0, pol, 1'b1}, 4'hF);
        for (int k = 0; k < ncyc; k++) begin
            chk($sformatf("pwm P%0d D%0d pol%0d k%0d", p, d, pol, k),
                {31'd0, pwm_out}, {31'd0, ref_pwm(k, p, d, pol)});
            @(negedge ACLK);
        end
        wexp = 16'((ncyc + 1) / p);
        axi_read(4'hC, rd);
        chk($sformatf("status P%0d D%0d", p, d), rd, {wexp, 15'd0, 1'b1});
        axi_write(4'h0, 32'd0, 4'hF);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp,
                                input logic [31:0] mask);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp; v.mask = mask;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        int          p, d;
        logic        pol;
        int          dsel;

        tests_run     = 0;
        tests_failed  = 0;
        S_AXI_AWADDR  = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        ARESETN       = 1'b1;
        #1 ARESETN    = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge ACLK);
        chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        chk("rst_wready",  {31'd0, S_AXI_WREADY},  32'd0);
        chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        chk("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
        chk("rst_rdata",   S_AXI_RDATA,            32'd0);
        chk("rst_pwm",     {31'd0, pwm_out},       32'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("idle_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("idle_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // ---------------- register table ----------------
        vecs.push_back(mk(1, 4'h4, 32'h1234_5678, 4'hF, 0, 0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 32'h1234_5678, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 4'h4, 32'hAABB_CCDD, 4'b0101, 0, 0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 32'h12BB_56DD, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 4'h8, 32'hFFFF_FFFF, 4'b1000, 0, 0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 32'hFF00_0000, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 4'h0, 32'hFFFF_FFFE, 4'hF, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 32'h0000_0002, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 4'h0, 32'h0000_0003, 4'b1110, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 32'h0000_0002, 32'hFFFF_FFFF));
        vecs.push_back(mk(0, 4'hC, 0, 0, 32'h0000_0000, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0));
        vecs.push_back(mk(0, 4'hC, 0, 0, 32'h0000_0000, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 4'h0, 32'h0, 4'hF, 0, 0));
        vecs.push_back(mk(1, 4'h4, 32'h0, 4'hF, 0, 0));
        vecs.push_back(mk(1, 4'h8, 32'h0, 4'hF, 0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h1, 4'hF, 0, 0));
        vecs.push_back(mk(1, 4'h4, 32'h2, 4'hF, 0, 0));
        vecs.push_back(mk(1, 4'h8, 32'h3, 4'hF, 0, 0));
        vecs.push_back(mk(1, 4'hC, 32'h4, 4'hF, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 32'h1, 32'hFFFF_FFFF));
        vecs.push_back(mk(0, 4'h4, 0, 0, 32'h2, 32'hFFFF_FFFF));
        vecs.push_back(mk(0, 4'h8, 0, 0, 32'h3, 32'hFFFF_FFFF));
        vecs.push_back(mk(0, 4'hC, 0, 0, 32'h0, 32'h0000_FFFE));
        vecs.push_back(mk(1, 4'h0, 32'h0, 4'hF, 0, 0));
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, rd);
                chk($sformatf("vec%0d addr 0x%0h", i, vecs[i].addr),
                    rd & vecs[i].mask, vecs[i].exp & vecs[i].mask);
            end
        end

        // ---------------- PWM: directed corners then random ----------------
        run_pwm(10, 3, 1'b0, 35);
        run_pwm(10, 12, 1'b0, 15);
        run_pwm(10, 0, 1'b0, 15);
        run_pwm(10, 0, 1'b1, 15);
        run_pwm(1, 1, 1'b0, 6);
        for (int t = 0; t < 8; t++) begin
            p    = $urandom_range(12, 1);
            dsel = $urandom_range(3, 0);
            d    = (dsel == 0) ? 0 : (dsel == 1) ? p + $urandom_range(3, 0)
                                                 : $urandom_range(p, 0);
            pol  = 1'($urandom_range(1, 0));
            run_pwm(p, d, pol, 2 * p + $urandom_range(10, 3));
        end

        // ---------------- polarity flip while running ----------------
        axi_write(4'h4, 32'd10, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        for (int k = 0; k < 25; k++) begin
            chk($sformatf("pol0 k%0d", k), {31'd0, pwm_out}, {31'd0, ref_pwm(k, 10, 3, 1'b0)});
            @(negedge ACLK);
        end
        axi_write(4'h0, 32'd3, 4'hF);
        for (int k = 27; k < 47; k++) begin
            chk($sformatf("pol1 k%0d", k), {31'd0, pwm_out}, {31'd0, ref_pwm(k, 10, 3, 1'b1)});
            @(negedge ACLK);
        end
        axi_write(4'h0, 32'd0, 4'hF);

        // ---------------- DUTY change mid-period (commit at cnt=5) ----------------
        axi_write(4'h0, 32'd1, 4'hF);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dchg pre k%0d", k), {31'd0, pwm_out}, {31'd0, ref_pwm(k, 10, 3, 1'b0)});
            @(negedge ACLK);
        end
        axi_write(4'h8, 32'd7, 4'hF);
        for (int k = 6; k < 30; k++) begin
`ifdef PWM_GEN_SHADOW_EN
            d = (k < 10) ? 3 : 7;
`else
            d = 7;
`endif
            chk($sformatf("dchg post k%0d", k), {31'd0, pwm_out}, {31'd0, ref_pwm(k, 10, d, 1'b0)});
            @(negedge ACLK);
        end
        axi_write(4'h0, 32'd0, 4'hF);

        // ---------------- PERIOD = 0 with en = 1 ----------------
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h8, 32'd5, 4'hF);
        axi_write(4'h0, 32'd3, 4'hF);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("p0 pwm k%0d", k), {31'd0, pwm_out}, 32'd1);
            @(negedge ACLK);
        end
        axi_read(4'hC, rd);
        chk("p0 status", rd, 32'd0);
        axi_write(4'h0, 32'd0, 4'hF);

        // ---------------- W before AW, BREADY held low ----------------
        S_AXI_WDATA  = 32'h55;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        chk("w_latched_wready", {31'd0, S_AXI_WREADY}, 32'd0);
        chk("w_only_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        repeat (2) begin
            @(negedge ACLK);
            chk("w_only_bvalid_wait", {31'd0, S_AXI_BVALID}, 32'd0);
        end
        S_AXI_AWADDR  = 4'h8;
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("late_aw_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        S_AXI_AWADDR = 4'h4;
        S_AXI_WDATA  = 32'hDEAD;
        S_AXI_WVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bhold_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
            chk("bhold_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
            chk("bhold_wready", {31'd0, S_AXI_WREADY}, 32'd0);
            @(negedge ACLK);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        chk("bready_clears", {31'd0, S_AXI_BVALID}, 32'd0);
        axi_read(4'h8, rd);
        chk("hs_duty", rd, 32'h55);
        axi_read(4'h4, rd);
        chk("hs_no_second_write", rd, 32'd0);

        // ---------------- RREADY held low ----------------
        S_AXI_ARADDR  = 4'h8;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("rhold_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
            chk("rhold_rdata", S_AXI_RDATA, 32'h55);
            chk("rhold_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
            @(negedge ACLK);
        end
        axi_write(4'h8, 32'h99, 4'hF);
        chk("rhold_rdata_after_wr", S_AXI_RDATA, 32'h55);
        chk("rhold_rvalid_after_wr", {31'd0, S_AXI_RVALID}, 32'd1);
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        chk("rready_clears", {31'd0, S_AXI_RVALID}, 32'd0);
        axi_read(4'h8, rd);
        chk("duty_new", rd, 32'h99);

        // ---------------- async reset mid-write / mid-period ----------------
        axi_write(4'h4, 32'd10, 4'hF);
        axi_write(4'h8, 32'd5, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        @(negedge ACLK);
        S_AXI_ARADDR  = 4'h0;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'd3;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("pre_rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        chk("pre_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
        #3 ARESETN = 1'b0;
        #1;
        chk("async_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("async_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("async_rdata", S_AXI_RDATA, 32'd0);
        chk("async_pwm", {31'd0, pwm_out}, 32'd0);
        chk("async_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), rd);
            chk($sformatf("post_rst_reg%0d", a), rd, 32'd0);
        end
        chk("post_rst_pwm", {31'd0, pwm_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
